// File: rtl/hrange_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hrange_pkg
//  Description : Shared types and constants for the hrange generator arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package hrange_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int N_REQ_DEFAULT = 4;

  // Arbiter ownership state: IDLE can launch, BUSY routes the stream to owner.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Round-robin successor that wraps at the requester count, not at a power of 2.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hrange_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : hrange_arbiter_rr_pick
//  Description : Combinational round-robin picker. Returns the first asserted
//                request at or after the pointer, wrapping at N_REQ.
//  Revision    : 1.0  initial release
// ============================================================================
module hrange_arbiter_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  int               w_sum;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Scan candidates ptr, ptr+1, ... (mod N_REQ); the first hit wins.
  always_comb begin
    w_sum   = 0;
    w_cand  = '0;
    w_found = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = int'(ptr_i) + k;
      if (w_sum >= N_REQ) begin
        w_sum = w_sum - N_REQ;
      end
      w_cand = IDX_W'(w_sum);
      if (!w_found && req_i[w_cand]) begin
        w_found = 1'b1;
        idx_o   = w_cand;
      end
    end
    any_o = w_found;
  end

endmodule
`default_nettype wire

// File: rtl/hrange_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hrange_arbiter
//  Description : Shares one hrange generator among N_REQ callers. Grants start
//                requests round-robin, launches the generator with the
//                winner's arguments and routes the ready/valid stream and the
//                done pulse between generator and owner until exhaustion.
//  Revision    : 1.0  initial release
// ============================================================================
module hrange_arbiter
  import hrange_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEFAULT,
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                   _clock,
  input  logic                   _reset_n,
  // caller side
  input  logic [N_REQ-1:0]       req_start,
  input  logic [N_REQ*WIDTH-1:0] req_base,
  input  logic [N_REQ*WIDTH-1:0] req_limit,
  input  logic [N_REQ*WIDTH-1:0] req_step,
  output logic [N_REQ-1:0]       req_grant,
  input  logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       req_valid,
  output logic [WIDTH-1:0]       req_0,
  output logic [N_REQ-1:0]       req_done,
  output logic                   busy,
  output logic [IDX_W-1:0]       owner,
  // generator side
  output logic                   gen_reset,
  output logic                   gen_start,
  output logic [WIDTH-1:0]       gen_base,
  output logic [WIDTH-1:0]       gen_limit,
  output logic [WIDTH-1:0]       gen_step,
  output logic                   gen_ready,
  input  logic                   gen_valid,
  input  logic                   gen_done,
  input  logic [WIDTH-1:0]       gen_0
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  logic             w_any;
  logic [IDX_W-1:0] w_win;
  logic             w_launch;

  logic [WIDTH-1:0] w_base  [N_REQ];
  logic [WIDTH-1:0] w_limit [N_REQ];
  logic [WIDTH-1:0] w_step  [N_REQ];

  // Unpack the flat per-caller argument buses into indexable arrays.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_base[gi]  = req_base [gi*WIDTH +: WIDTH];
    assign w_limit[gi] = req_limit[gi*WIDTH +: WIDTH];
    assign w_step[gi]  = req_step [gi*WIDTH +: WIDTH];
  end

  hrange_arbiter_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_i (req_start),
    .ptr_i (rr_ptr_q),
    .any_o (w_any),
    .idx_o (w_win)
  );

  // A launch needs an idle generator, a pending request and reset released.
  assign w_launch = (state_q == ARB_IDLE) && w_any && _reset_n;

  // Next-state: grant moves ownership and advances the pointer past the winner.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (w_launch) begin
          state_d  = ARB_BUSY;
          owner_d  = w_win;
          rr_ptr_d = IDX_W'(rr_next(int'(w_win), N_REQ));
        end
      end
      ARB_BUSY: begin
        if (gen_done) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, pointer and owner registers; reset aborts any stream silently.
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // Zero-latency routing: launch args in IDLE, owner's stream in BUSY.
  always_comb begin
    req_grant = '0;
    req_valid = '0;
    req_done  = '0;
    req_0     = '0;
    gen_start = 1'b0;
    gen_base  = '0;
    gen_limit = '0;
    gen_step  = '0;
    gen_ready = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (w_launch) begin
          gen_start        = 1'b1;
          gen_base         = w_base[w_win];
          gen_limit        = w_limit[w_win];
          gen_step         = w_step[w_win];
          req_grant[w_win] = 1'b1;
        end
      end
      ARB_BUSY: begin
        gen_ready          = req_ready[owner_q];
        req_valid[owner_q] = gen_valid;
        req_done[owner_q]  = gen_done;
        req_0              = gen_0;
      end
      default: begin
        gen_ready = 1'b0;
      end
    endcase
  end

  assign gen_reset = ~_reset_n;
  assign busy      = (state_q == ARB_BUSY);
  assign owner     = owner_q;

endmodule
`default_nettype wire
